// File: rtl/pose_recorder.sv
// Pose recorder: samples the live joint-angle vector once per tick and writes frames to pose RAM.
// Define REC_LOOP_EN for ring-buffer recording (wraps at DEPTH, adds the wr_ptr output).
module pose_recorder #(
   parameter int unsigned NUM_JOINTS = 4,
   parameter int unsigned ANGLE_W    = 8,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned TICK_DIV   = 50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          btn_rec,
   input  logic [NUM_JOINTS*ANGLE_W-1:0] angles_in,
   input  logic                          angles_valid,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_waddr,
   output logic [NUM_JOINTS*ANGLE_W-1:0] mem_wdata,
   output logic [ADDR_W:0]               frame_count,
   output logic                          recording,
   output logic                          rec_done,
`ifdef REC_LOOP_EN
   output logic [ADDR_W-1:0]             wr_ptr,
`endif
   output logic                          full
);

   localparam int unsigned DataW = NUM_JOINTS * ANGLE_W;
   localparam int unsigned CntW  = ADDR_W + 1;
   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef REC_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StWaitTick, StCapture, StDone} state_e;

   state_e              state_q, state_d;
   logic [TickW-1:0]    tick_q, tick_d;
   logic [CntW-1:0]     frame_count_q, frame_count_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
   logic [DataW-1:0]    mem_wdata_q, mem_wdata_d;
   logic                btn_prev_q;
   logic                press;

   assign press = btn_rec & ~btn_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         tick_q        <= '0;
         frame_count_q <= '0;
         wr_ptr_q      <= '0;
         mem_we_q      <= 1'b0;
         mem_waddr_q   <= '0;
         mem_wdata_q   <= '0;
         btn_prev_q    <= 1'b1; // a button held through reset must not start a recording
      end else begin
         state_q       <= state_d;
         tick_q        <= tick_d;
         frame_count_q <= frame_count_d;
         wr_ptr_q      <= wr_ptr_d;
         mem_we_q      <= mem_we_d;
         mem_waddr_q   <= mem_waddr_d;
         mem_wdata_q   <= mem_wdata_d;
         btn_prev_q    <= btn_rec;
      end
   end

   always_comb begin
      state_d       = state_q;
      tick_d        = tick_q;
      frame_count_d = frame_count_q;
      wr_ptr_d      = wr_ptr_q;
      mem_we_d      = 1'b0;
      mem_waddr_d   = mem_waddr_q;
      mem_wdata_d   = mem_wdata_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (press && enable) begin
               frame_count_d = '0;
               wr_ptr_d      = '0;
               mem_waddr_d   = '0;
               tick_d        = '0;
               state_d       = StWaitTick;
            end
         end
         StWaitTick: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (press) begin
               state_d = StDone;
            end else if (tick_q == TickW'(TICK_DIV - 1)) begin
               tick_d  = '0;
               state_d = StCapture;
            end else begin
               tick_d = tick_q + TickW'(1);
            end
         end
         StCapture: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (angles_valid) begin
               mem_we_d    = 1'b1;
               mem_waddr_d = wr_ptr_q;
               mem_wdata_d = angles_in;
               wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
               tick_d      = '0;
               if (frame_count_q != CntW'(DEPTH)) frame_count_d = frame_count_q + CntW'(1);
               if (press || (!LoopEn && frame_count_d == CntW'(DEPTH))) state_d = StDone;
               else state_d = StWaitTick;
            end else if (press) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_we      = mem_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign frame_count = frame_count_q;
   assign recording   = (state_q == StWaitTick) || (state_q == StCapture);
   assign rec_done    = (state_q == StDone);
   assign full        = (frame_count_q == CntW'(DEPTH));
`ifdef REC_LOOP_EN
   assign wr_ptr      = wr_ptr_q;
`endif

endmodule

// File: tb/tb_pose_recorder.sv
// Scoreboard bench for pose_recorder: stimulus queues expected RAM writes, a monitor checks them.
module tb_pose_recorder;

   localparam int unsigned NJ = 4, AW = 8, DEP = 4, ADW = 2, TD = 4;

   logic             clk = 1'b0;
   logic             rst, enable, btn_rec, angles_valid;
   logic [31:0]      angles_in;
   logic             mem_we, recording, rec_done, full;
   logic [ADW-1:0]   mem_waddr;
   logic [31:0]      mem_wdata;
   logic [ADW:0]     frame_count;
`ifdef REC_LOOP_EN
   logic [ADW-1:0]   wr_ptr;
`endif

   pose_recorder #(
      .NUM_JOINTS(NJ), .ANGLE_W(AW), .DEPTH(DEP), .ADDR_W(ADW), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .btn_rec(btn_rec),
      .angles_in(angles_in), .angles_valid(angles_valid),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .frame_count(frame_count), .recording(recording), .rec_done(rec_done),
`ifdef REC_LOOP_EN
      .wr_ptr(wr_ptr),
`endif
      .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADW-1:0] addr;
      logic [31:0]    data;
      int             gap;   // expected cycles since previous write, 0 = unchecked
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_btn();
      btn_rec = 1'b1;
      step();
      btn_rec = 1'b0;
   endtask

   task automatic push(input logic [ADW-1:0] a, input logic [31:0] d, input int g);
      exp_t e;
      e.addr = a; e.data = d; e.gap = g;
      exp_q.push_back(e);
   endtask

   task automatic wait_we(input string name, input int max);
      int k;
      k = 0;
      while (mem_we !== 1'b1 && k < max) begin
         step();
         k++;
      end
      if (mem_we !== 1'b1) check({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every write strobe must match the head of the scoreboard
   initial begin
      int  last_cyc;
      bit  prev_we;
      exp_t e;
      last_cyc = 0;
      prev_we  = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            if (prev_we) check("mem_we_back_to_back", 1'b1, 1'b0);
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(mem_waddr), 64'(e.addr));
               check("wr_data", 64'(mem_wdata), 64'(e.data));
               if (e.gap != 0) check("wr_gap", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
         end
         prev_we = (mem_we === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; btn_rec = 1'b0; angles_valid = 1'b0; angles_in = '0;
      step(3);
      rst = 1'b0;
      step();
      check("rst_mem_we", 64'(mem_we), 0);
      check("rst_waddr", 64'(mem_waddr), 0);
      check("rst_wdata", 64'(mem_wdata), 0);
      check("rst_count", 64'(frame_count), 0);
      check("rst_status", {61'd0, recording, rec_done, full}, 0);

`ifndef REC_LOOP_EN
      // Basic record to full
      enable = 1'b1; angles_valid = 1'b1; angles_in = 32'h11223344;
      push(0, 32'h11223344, 0);
      press_btn();
      check("basic_recording", 64'(recording), 1);
      step(4);
      check("basic_no_early_we", 64'(mem_we), 0);
      step();
      check("basic_first_latency", 64'(mem_we), 1);
      for (int i = 1; i < 4; i++) begin
         angles_in = 32'h11223344 + 32'(i);
         push(ADW'(i), 32'h11223344 + 32'(i), 5);
         step();
         wait_we("basic_we", 10);
      end
      check("basic_done", 64'(rec_done), 1);
      check("basic_count", 64'(frame_count), 4);
      check("basic_full", 64'(full), 1);
      step();
      check("basic_hold_addr", 64'(mem_waddr), 3);
      check("basic_hold_data", 64'(mem_wdata), 32'h11223347);
      step(12);
      check("basic_stays_done", 64'(rec_done), 1);
`endif

      // Stop early after two writes
      enable = 1'b1; angles_valid = 1'b1; angles_in = 32'hA0;
      push(0, 32'hA0, 0);
      press_btn();
      wait_we("stop_we0", 10);
      angles_in = 32'hA1;
      push(1, 32'hA1, 5);
      step();
      wait_we("stop_we1", 10);
      press_btn();
      step(12);
      check("stop_done", 64'(rec_done), 1);
      check("stop_count", 64'(frame_count), 2);
      check("stop_not_full", 64'(full), 0);

      // Valid stall in CAPTURE
      angles_valid = 1'b0; angles_in = 32'hB0;
      press_btn();
      step(4);
      step(10);
      check("stall_recording", 64'(recording), 1);
      check("stall_count", 64'(frame_count), 0);
      angles_valid = 1'b1;
      push(0, 32'hB0, 0);
      step();
      check("stall_we_after_valid", 64'(mem_we), 1);
      angles_in = 32'hB1;
      push(1, 32'hB1, 5);
      step();
      wait_we("stall_we1", 10);
      press_btn();
      step();

      // Abort in WAIT_TICK after one write
      angles_in = 32'hC0;
      push(0, 32'hC0, 0);
      press_btn();
      wait_we("abort_we", 10);
      enable = 1'b0;
      step();
      check("abort_idle", {62'd0, recording, rec_done}, 0);
      check("abort_count", 64'(frame_count), 1);
      press_btn();
      step(8);
      check("abort_press_ignored", 64'(recording), 0);

      // Abort in CAPTURE with valid high: no write
      enable = 1'b1; angles_valid = 1'b0;
      press_btn();
      step(4);
      enable = 1'b0; angles_valid = 1'b1;
      step();
      check("abort_cap_no_we", 64'(mem_we), 0);
      check("abort_cap_idle", 64'(recording), 0);
      check("abort_cap_count", 64'(frame_count), 0);

      // Stop press coincident with capture
      enable = 1'b1; angles_valid = 1'b0; angles_in = 32'hD0;
      press_btn();
      step(4);
      angles_valid = 1'b1; btn_rec = 1'b1;
      push(0, 32'hD0, 0);
      step();
      btn_rec = 1'b0;
      check("coinc_we", 64'(mem_we), 1);
      check("coinc_done", 64'(rec_done), 1);
      check("coinc_count", 64'(frame_count), 1);
      step(8);

      // Button held through reset
      btn_rec = 1'b1; rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(6);
      check("rst_btn_held_idle", {62'd0, recording, rec_done}, 0);
      btn_rec = 1'b0;
      step();

      // Reset mid WAIT_TICK
      press_btn();
      step(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_outputs", {mem_we, mem_waddr, mem_wdata, frame_count}, 0);
      check("midrst_status", {61'd0, recording, rec_done, full}, 0);
      step(10);
      check("midrst_stays_idle", 64'(recording), 0);

`ifdef REC_LOOP_EN
      // Ring buffer: six frames wrap the address
      angles_valid = 1'b1; angles_in = 32'hE0;
      push(0, 32'hE0, 0);
      press_btn();
      wait_we("loop_we0", 10);
      for (int i = 1; i < 6; i++) begin
         angles_in = 32'hE0 + 32'(i);
         push(ADW'(i % 4), 32'hE0 + 32'(i), 5);
         step();
         wait_we("loop_we", 10);
      end
      check("loop_count", 64'(frame_count), 4);
      check("loop_full", 64'(full), 1);
      check("loop_wr_ptr", 64'(wr_ptr), 2);
      check("loop_recording", 64'(recording), 1);
      press_btn();
      check("loop_stop_done", 64'(rec_done), 1);
      step(4);
`endif

      check("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
